imm_gen_pipe: RTL

Parametrised, pipelined immediate generator for the decode stage. It accepts one instruction word per cycle over a valid/ready handshake and classifies the format as I, S, B, U or J. It produces the sign-extended immediate at XLEN width, flags unsupported opcodes, and carries a sideband tag (normally the PC) alongside. A 2-entry output buffer absorbs execute-stage stalls without losing throughput.

---
 rtl/imm_gen_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with a 2-entry output FIFO.
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready: instruction handshake (in_ready from registered state)
//   in_inst, in_tag  : instruction word and sideband tag (normally the PC)
//   out_valid/ready  : result handshake, head of FIFO
//   out_imm          : sign-extended immediate, XLEN wide
//   out_fmt          : 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
//   out_illegal      : opcode not supported
//   out_tag          : tag carried with the instruction
module imm_gen_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BYTE_OFFSET = 1,
  parameter int unsigned TAG_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           dec;
  logic [2:0]       dec_fmt;
  logic [XLEN-1:0]  dec_imm;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  entry_t           out_q, out_d;
  logic             push, pop;

  // Format classification; RV64-only OP-IMM-32 is illegal on 32-bit datapaths.
  always_comb begin
    dec_fmt = FMT_NONE;
    case (in_inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: dec_fmt = FMT_I;
      OPC_OP_IMM32: if (XLEN == 64) dec_fmt = FMT_I;
      OPC_STORE:    dec_fmt = FMT_S;
      OPC_BRANCH:   dec_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC: dec_fmt = FMT_U;
      OPC_JAL:      dec_fmt = FMT_J;
      default:      dec_fmt = FMT_NONE;
    endcase
  end

  // Immediate assembly; signed casts perform the sign extension to XLEN.
  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      FMT_I: dec_imm = XLEN'($signed(in_inst[31:20]));
      FMT_S: dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      FMT_B: begin
        if (BYTE_OFFSET != 0)
          dec_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                   in_inst[11:8], 1'b0}));
        else
          dec_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                   in_inst[11:8]}));
      end
      FMT_U: dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      FMT_J: begin
        if (BYTE_OFFSET != 0)
          dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                   in_inst[30:21], 1'b0}));
        else
          dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                   in_inst[30:21]}));
      end
      default: dec_imm = '0;
    endcase
  end

  always_comb begin
    dec.imm     = dec_imm;
    dec.fmt     = dec_fmt;
    dec.illegal = (dec_fmt == FMT_NONE);
    dec.tag     = in_tag;
  end

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // FIFO next state; the output registers are loaded with the next head so
  // every out_* port is a flop.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      ent_d[tail_q] = dec;
      tail_d        = ~tail_q;
    end
    if (pop) head_d = ~head_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    in_ready_d  = (count_d != CNT_W'(DEPTH));
    out_valid_d = (count_d != '0);
    out_d       = ent_d[head_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;

endmodule
